serial_adder_ctrl: RTL and testbench

Bit-serial adder controller that shares a single one-bit full-adder cell across all bit positions of a WIDTH-bit add. It accepts an operand pair over a valid/ready handshake and feeds one bit pair per cycle, LSB first, through the cell. It accumulates the sum in a shift register and presents the result over a second valid/ready handshake. It is the sequencing block that turns the one-bit adder cell into a multi-cycle word adder for the lab datapath.

---
 rtl/serial_adder_pkg.sv | 18 +
 rtl/full_adder.sv | 25 ++
 rtl/serial_adder_ctrl.sv | 141 ++++++++++++++
 tb/tb_serial_adder_ctrl.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// -----------------------------------------------------------------------------
// serial_adder_pkg
// Shared definitions for the bit-serial adder controller:
//   - state_t      : 2-bit controller state type
//   - ST_IDLE/RUN/DONE : state encodings
//   - DEFAULT_WIDTH: default operand/sum width
// -----------------------------------------------------------------------------
package serial_adder_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_RUN  = 2'd1;
    localparam state_t ST_DONE = 2'd2;

endpackage : serial_adder_pkg

// File: rtl/full_adder.sv
// -----------------------------------------------------------------------------
// full_adder
// One-bit full-adder cell, shared across every bit position by the serial
// adder controller.
// Ports:
//   a, b      : operand bits
//   carry_in  : incoming carry
//   sum       : sum bit
//   carry_out : outgoing carry
// -----------------------------------------------------------------------------
module full_adder (
    input  logic a,
    input  logic b,
    input  logic carry_in,
    output logic sum,
    output logic carry_out
);

    logic half_sum;

    assign half_sum  = a ^ b;
    assign sum       = half_sum ^ carry_in;
    assign carry_out = (a & b) | (carry_in & half_sum);

endmodule : full_adder

// File: rtl/serial_adder_ctrl.sv
// -----------------------------------------------------------------------------
// serial_adder_ctrl
// Bit-serial word adder: accepts an operand pair over a valid/ready handshake,
// feeds one bit pair per cycle (LSB first) through a single full_adder cell,
// collects the sum in a shift register and returns it over a second
// valid/ready handshake. Latency is WIDTH cycles from the accept edge.
//
// Ports:
//   clk, rst            : clock, asynchronous active-high reset
//   in_valid / in_ready : operand handshake (in_ready high only in IDLE)
//   a, b                : operands, sampled only on the input handshake
//   sub                 : subtract select (only with SERIAL_ADDER_SUB_EN)
//   out_valid/out_ready : result handshake (out_valid high only in DONE)
//   sum, carry_out      : result word and carry out of the MSB
//
// Build option:
//   SERIAL_ADDER_SUB_EN : adds the sub port; sub=1 computes a-b, and
//                         carry_out=1 then means "no borrow".
// -----------------------------------------------------------------------------
module serial_adder_ctrl
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out
);

    localparam int               CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_t           state_q,  state_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;
    logic [WIDTH-1:0] a_sh_q,   a_sh_d;
    logic [WIDTH-1:0] b_sh_q,   b_sh_d;
    logic [WIDTH-1:0] sum_sh_q, sum_sh_d;
    logic             carry_q,  carry_d;

    logic [WIDTH-1:0] b_load;
    logic             carry_load;
    logic             fa_sum;
    logic             fa_carry;

`ifdef SERIAL_ADDER_SUB_EN
    // a - b = a + ~b + 1: invert B and seed the carry with the subtract bit.
    assign b_load     = b ^ {WIDTH{sub}};
    assign carry_load = sub;
`else
    assign b_load     = b;
    assign carry_load = 1'b0;
`endif

    full_adder u_full_adder (
        .a         (a_sh_q[0]),
        .b         (b_sh_q[0]),
        .carry_in  (carry_q),
        .sum       (fa_sum),
        .carry_out (fa_carry)
    );

    always_comb begin
        // NOTE: every next-state signal gets a hold default first, so no
        // path through the case statement can leave one unassigned (latch).
        state_d  = state_q;
        cnt_d    = cnt_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        sum_sh_d = sum_sh_q;
        carry_d  = carry_q;

        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    a_sh_d  = a;
                    b_sh_d  = b_load;
                    carry_d = carry_load;
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                a_sh_d   = {1'b0, a_sh_q[WIDTH-1:1]};
                b_sh_d   = {1'b0, b_sh_q[WIDTH-1:1]};
                sum_sh_d = {fa_sum, sum_sh_q[WIDTH-1:1]};
                carry_d  = fa_carry;
                // The counter saturates on the last bit instead of wrapping.
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge value of every other flop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            sum_sh_q <= '0;
            carry_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            sum_sh_q <= sum_sh_d;
            carry_q  <= carry_d;
        end
    end

    // Moore outputs: decoded from registered state only.
    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign sum       = sum_sh_q;
    assign carry_out = carry_q;

endmodule : serial_adder_ctrl

// File: tb/tb_serial_adder_ctrl.sv
// -----------------------------------------------------------------------------
// tb_serial_adder_ctrl
// Self-checking bench for serial_adder_ctrl (WIDTH=8). Expected results come
// from plain word arithmetic on the operands. Define SERIAL_ADDER_SUB_EN to
// also exercise subtraction.
// -----------------------------------------------------------------------------
module tb_serial_adder_ctrl;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
`ifdef SERIAL_ADDER_SUB_EN
    logic         sub_i;
`endif
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         carry_out;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    serial_adder_ctrl #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
`ifdef SERIAL_ADDER_SUB_EN
        .sub       (sub_i),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .carry_out (carry_out)
    );

    // Issue one operation with out_ready=1 and report what came back.
    // lat counts clock edges after the accept edge until out_valid is seen.
    task automatic do_op(input logic [W-1:0] av, input logic [W-1:0] bv,
                         output logic [W-1:0] s, output logic co,
                         output int lat, output logic valid_after);
        int guard;
        @(negedge clk);
        a = av; b = bv; in_valid = 1'b1; out_ready = 1'b1;
        guard = 0;
        while (!in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        @(negedge clk);
        in_valid = 1'b0;
        // Operands must be ignored once accepted.
        a = W'($urandom); b = W'($urandom);
        lat = 0;
        while (!out_valid && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        s  = sum;
        co = carry_out;
        @(negedge clk);
        valid_after = out_valid;
    endtask

    task automatic test_reset();
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++; if (sum !== 8'h00) begin errors++; $display("FAIL reset_sum got=%h exp=00", sum); end
        checks++; if (carry_out !== 1'b0) begin errors++; $display("FAIL reset_carry got=%b exp=0", carry_out); end
    endtask

    task automatic test_add(input logic [W-1:0] av, input logic [W-1:0] bv, input string tag);
        logic [W-1:0] s;
        logic         co;
        logic         va;
        int           lat;
        logic [W:0]   exp;
        exp = {1'b0, av} + {1'b0, bv};
        do_op(av, bv, s, co, lat, va);
        checks++; if (s !== exp[W-1:0]) begin errors++; $display("FAIL %s_sum a=%h b=%h got=%h exp=%h", tag, av, bv, s, exp[W-1:0]); end
        checks++; if (co !== exp[W]) begin errors++; $display("FAIL %s_carry a=%h b=%h got=%b exp=%b", tag, av, bv, co, exp[W]); end
        checks++; if (lat !== W) begin errors++; $display("FAIL %s_latency got=%0d exp=%0d", tag, lat, W); end
        checks++; if (va !== 1'b0) begin errors++; $display("FAIL %s_valid_pulse got=%b exp=0", tag, va); end
    endtask

    task automatic test_directed();
        test_add(8'h2D, 8'h1A, "add_2d_1a");
        test_add(8'hFF, 8'h01, "add_ff_01");
        test_add(8'hFF, 8'hFF, "add_ff_ff");
        test_add(8'h00, 8'h00, "add_00_00");
    endtask

    task automatic test_random();
        for (int i = 0; i < 6; i++) begin
            test_add(W'($urandom), W'($urandom), "add_rand");
        end
    endtask

    task automatic test_backpressure();
        logic [W-1:0] a1, b1, a2, b2;
        logic [W:0]   e1, e2;
        int           lat;
        int           guard;
        a1 = W'($urandom); b1 = W'($urandom);
        a2 = W'($urandom); b2 = W'($urandom);
        e1 = {1'b0, a1} + {1'b0, b1};
        e2 = {1'b0, a2} + {1'b0, b2};
        @(negedge clk);
        a = a1; b = b1; in_valid = 1'b1; out_ready = 1'b0;
        guard = 0;
        while (!in_ready && guard < 50) begin @(negedge clk); guard++; end
        @(negedge clk);
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 50) begin @(negedge clk); lat++; end
        checks++; if (lat !== W) begin errors++; $display("FAIL bp_latency got=%0d exp=%0d", lat, W); end
        // Stall in DONE while offering new operands.
        a = a2; b = b2; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_hold_valid cyc=%0d got=%b exp=1", i, out_valid); end
            checks++; if (sum !== e1[W-1:0]) begin errors++; $display("FAIL bp_hold_sum cyc=%0d got=%h exp=%h", i, sum, e1[W-1:0]); end
            checks++; if (carry_out !== e1[W]) begin errors++; $display("FAIL bp_hold_carry cyc=%0d got=%b exp=%b", i, carry_out, e1[W]); end
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_hold_in_ready cyc=%0d got=%b exp=0", i, in_ready); end
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_release_valid got=%b exp=0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_in_ready got=%b exp=1", in_ready); end
        @(negedge clk);
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_second_accept got=%b exp=0", in_ready); end
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 50) begin @(negedge clk); lat++; end
        checks++; if (lat !== W) begin errors++; $display("FAIL bp2_latency got=%0d exp=%0d", lat, W); end
        checks++; if (sum !== e2[W-1:0]) begin errors++; $display("FAIL bp2_sum got=%h exp=%h", sum, e2[W-1:0]); end
        checks++; if (carry_out !== e2[W]) begin errors++; $display("FAIL bp2_carry got=%b exp=%b", carry_out, e2[W]); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_run();
        int guard;
        @(negedge clk);
        a = 8'hA7; b = 8'h6C; in_valid = 1'b1; out_ready = 1'b1;
        guard = 0;
        while (!in_ready && guard < 50) begin @(negedge clk); guard++; end
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_run_out_valid got=%b exp=0", out_valid); end
        checks++; if (sum !== 8'h00) begin errors++; $display("FAIL rst_run_sum got=%h exp=00", sum); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_run_in_ready got=%b exp=1", in_ready); end
        @(negedge clk);
        rst = 1'b0;
        test_add(8'h05, 8'h03, "post_rst");
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] pa[4];
        logic [W-1:0] pb[4];
        logic [W:0]   exp;
        int           acc_cyc[4];
        int           acc_n;
        int           res_n;
        int           cyc;
        for (int k = 0; k < 4; k++) begin
            pa[k] = W'($urandom); pb[k] = W'($urandom); acc_cyc[k] = 0;
        end
        acc_n = 0; res_n = 0; cyc = 0;
        @(negedge clk);
        in_valid = 1'b1; out_ready = 1'b1;
        while (res_n < 4 && cyc < 100) begin
            if (out_valid) begin
                exp = {1'b0, pa[res_n]} + {1'b0, pb[res_n]};
                checks++; if ({carry_out, sum} !== exp) begin errors++; $display("FAIL b2b_result idx=%0d got=%h exp=%h", res_n, {carry_out, sum}, exp); end
                res_n++;
            end
            if (in_ready) begin
                if (acc_n < 4) begin
                    a = pa[acc_n]; b = pb[acc_n];
                    acc_cyc[acc_n] = cyc;
                    acc_n++;
                end else begin
                    in_valid = 1'b0;
                end
            end
            @(negedge clk);
            cyc++;
        end
        in_valid = 1'b0;
        checks++; if (res_n !== 4) begin errors++; $display("FAIL b2b_results_seen got=%0d exp=4", res_n); end
        for (int k = 1; k < 4; k++) begin
            checks++; if (acc_cyc[k] - acc_cyc[k-1] !== W + 2) begin errors++; $display("FAIL b2b_spacing idx=%0d got=%0d exp=%0d", k, acc_cyc[k] - acc_cyc[k-1], W + 2); end
        end
        @(negedge clk);
    endtask

`ifdef SERIAL_ADDER_SUB_EN
    task automatic test_sub_one(input logic [W-1:0] av, input logic [W-1:0] bv);
        logic [W-1:0] s;
        logic         co;
        logic         va;
        int           lat;
        logic [W-1:0] exp_s;
        logic         exp_co;
        exp_s  = av - bv;
        exp_co = (av >= bv);
        do_op(av, bv, s, co, lat, va);
        checks++; if (s !== exp_s) begin errors++; $display("FAIL sub_diff a=%h b=%h got=%h exp=%h", av, bv, s, exp_s); end
        checks++; if (co !== exp_co) begin errors++; $display("FAIL sub_noborrow a=%h b=%h got=%b exp=%b", av, bv, co, exp_co); end
        checks++; if (lat !== W) begin errors++; $display("FAIL sub_latency got=%0d exp=%0d", lat, W); end
    endtask

    task automatic test_sub();
        sub_i = 1'b1;
        test_sub_one(8'h10, 8'h01);
        test_sub_one(8'h00, 8'h01);
        for (int i = 0; i < 4; i++) begin
            test_sub_one(W'($urandom), W'($urandom));
        end
        sub_i = 1'b0;
    endtask
`endif

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
`ifdef SERIAL_ADDER_SUB_EN
        sub_i = 1'b0;
`endif
        repeat (2) @(negedge clk);
        test_reset();
        rst = 1'b0;
        test_directed();
        test_random();
        test_backpressure();
        test_reset_mid_run();
        test_back_to_back();
`ifdef SERIAL_ADDER_SUB_EN
        test_sub();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_serial_adder_ctrl
